// File: rtl/memory_seq_pkg.sv
// Constants and state type shared by the external-SRAM sequencers:
// blanking writer, read-back checker and any later read-side sequencers.
package memory_seq_pkg;

  localparam int unsigned MEM_ADDR_WIDTH     = 18;
  localparam int unsigned MEM_DATA_WIDTH     = 32;
  localparam logic [31:0] BLANK_PATTERN      = 32'h77553311;
  localparam int unsigned BLANK_LAST_ADDRESS = 262141;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/read_tag_pipe.sv
// Depth-N shift register of {valid, tag}. It tracks which address each returning
// read word belongs to, so a read can be matched with its data.
module read_tag_pipe #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned TAG_WIDTH = 18
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 push_valid,
  input  logic [TAG_WIDTH-1:0] push_tag,
  output logic                 out_valid,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 busy
);

  logic [DEPTH-1:0]     valid_q;
  logic [TAG_WIDTH-1:0] tag_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      valid_q[0] <= push_valid;
      tag_q[0]   <= push_tag;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];
  assign busy      = |valid_q;

endmodule

// File: rtl/memory_verify.sv
// Read-back checker for the external SRAM. It sweeps 0..LAST_ADDRESS and compares every word
// with the blanking pattern. It reports the error count and the first failing address and data.
module memory_verify
  import memory_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = MEM_ADDR_WIDTH,
  parameter int unsigned LAST_ADDRESS = BLANK_LAST_ADDRESS,
  parameter logic [31:0] PATTERN      = BLANK_PATTERN,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pause,
  input  logic [31:0]           data_read,
  output logic                  wren,
  output logic [ADDR_WIDTH-1:0] address,
  input  logic                  enable,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   error_count,
  output logic [ADDR_WIDTH-1:0] first_error_address,
  output logic [31:0]           first_error_data
);

  localparam int unsigned CW       = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST   = CW'(LAST_ADDRESS);
  localparam logic [CW-1:0] ERR_MAX = '1;

  seq_state_e            state_q, state_d;
  logic [CW-1:0]         counter_q, counter_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [CW-1:0]         error_count_q, error_count_d;
  logic [ADDR_WIDTH-1:0] first_addr_q, first_addr_d;
  logic [31:0]           first_data_q, first_data_d;

  logic                  push_valid;
  logic                  pipe_valid;
  logic [ADDR_WIDTH-1:0] pipe_tag;
  logic                  pipe_busy;

  // Dropping enable flushes in-flight reads so a restarted sweep never sees stale tags.
  read_tag_pipe #(
    .DEPTH    (READ_LATENCY),
    .TAG_WIDTH(ADDR_WIDTH)
  ) u_tag_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (!enable),
    .push_valid(push_valid),
    .push_tag  (counter_q[ADDR_WIDTH-1:0]),
    .out_valid (pipe_valid),
    .out_tag   (pipe_tag),
    .busy      (pipe_busy)
  );

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    address_d     = address_q;
    error_count_d = error_count_q;
    first_addr_d  = first_addr_q;
    first_data_d  = first_data_q;
    push_valid    = 1'b0;

    if (!enable) begin
      state_d       = IDLE;
      counter_d     = '0;
      address_d     = '0;
      error_count_d = '0;
      first_addr_d  = '0;
      first_data_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d       = ISSUE;
          counter_d     = '0;
          error_count_d = '0;
          first_addr_d  = '0;
          first_data_d  = '0;
        end
        ISSUE: begin
          if (!pause) begin
            address_d  = counter_q[ADDR_WIDTH-1:0];
            push_valid = 1'b1;
            counter_d  = counter_q + 1'b1;
            if (counter_q == LAST) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (!pipe_busy) state_d = DONE;
        end
        DONE: begin
        end
        default: state_d = IDLE;
      endcase

      if (pipe_valid && (data_read != PATTERN)) begin
        if (error_count_q != ERR_MAX) error_count_d = error_count_q + 1'b1;
        if (error_count_q == '0) begin
          first_addr_d = pipe_tag;
          first_data_d = data_read;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      counter_q     <= '0;
      address_q     <= '0;
      error_count_q <= '0;
      first_addr_q  <= '0;
      first_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      address_q     <= address_d;
      error_count_q <= error_count_d;
      first_addr_q  <= first_addr_d;
      first_data_q  <= first_data_d;
    end
  end

  assign wren                = 1'b0;
  assign address             = address_q;
  assign done                = (state_q == DONE);
  assign pass                = done && (error_count_q == '0);
  assign error_count         = error_count_q;
  assign first_error_address = first_addr_q;
  assign first_error_data    = first_data_q;

endmodule

// File: tb/tb_memory_verify.sv
// Randomised scoreboard bench for memory_verify: a reduced-range instance with a
// behavioural SRAM model, plus a tiny full-range instance where every word is wrong.
module tb_memory_verify;

  localparam int unsigned AW_A   = 10;
  localparam int unsigned LAST_A = 1019;
  localparam int unsigned RL_A   = 2;
  localparam int unsigned AW_B   = 2;
  localparam int unsigned LAST_B = 3;
  localparam int unsigned RL_B   = 4;
  localparam logic [31:0] PAT    = 32'h77553311;
  localparam logic [31:0] BAD_B  = 32'h0BADF00D;

  typedef struct {
    int unsigned done_cyc;
    logic        pass;
    int unsigned errs;
    int unsigned faddr;
    logic [31:0] fdata;
    int unsigned last;
  } exp_t;

  // mask bits: 0 addr, 1 errs, 2 faddr, 3 fdata, 4 done, 5 pass
  typedef struct {
    string       name;
    bit [5:0]    mask;
    logic [31:0] addr;
    logic [31:0] errs;
    logic [31:0] faddr;
    logic [31:0] fdata;
    logic        done;
    logic        pass;
  } probe_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            en_a = 1'b0, pause_a = 1'b0, en_b = 1'b0, pause_b = 1'b0;
  logic [31:0]     data_read_a = '0;
  logic [31:0]     data_read_b = BAD_B;
  logic            wren_a, done_a, pass_a, wren_b, done_b, pass_b;
  logic [AW_A-1:0] address_a, faddr_a;
  logic [AW_A:0]   errs_a;
  logic [31:0]     fdata_a, fdata_b;
  logic [AW_B-1:0] address_b, faddr_b;
  logic [AW_B:0]   errs_b;

  int unsigned cyc = 0;
  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          finish_req = 1'b0;
  logic [31:0] corrupt [int];
  exp_t        exp_a[$];
  exp_t        exp_b[$];
  probe_t      probe_q[$];

  memory_verify #(
    .ADDR_WIDTH  (AW_A),
    .LAST_ADDRESS(LAST_A),
    .READ_LATENCY(RL_A)
  ) dut_a (
    .clk                (clk),
    .reset_n            (reset_n),
    .pause              (pause_a),
    .data_read          (data_read_a),
    .wren               (wren_a),
    .address            (address_a),
    .enable             (en_a),
    .done               (done_a),
    .pass               (pass_a),
    .error_count        (errs_a),
    .first_error_address(faddr_a),
    .first_error_data   (fdata_a)
  );

  memory_verify #(
    .ADDR_WIDTH  (AW_B),
    .LAST_ADDRESS(LAST_B),
    .READ_LATENCY(RL_B)
  ) dut_b (
    .clk                (clk),
    .reset_n            (reset_n),
    .pause              (pause_b),
    .data_read          (data_read_b),
    .wren               (wren_b),
    .address            (address_b),
    .enable             (en_b),
    .done               (done_b),
    .pass               (pass_b),
    .error_count        (errs_b),
    .first_error_address(faddr_b),
    .first_error_data   (fdata_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input int a);
    return corrupt.exists(a) ? corrupt[a] : PAT;
  endfunction

  // SRAM model: the word for an address launched at edge j is on data_read
  // from RL_A-1 cycles after that address appears until edge j+RL_A.
  int hist[$];
  always @(posedge clk) begin
    #1;
    hist.push_back(int'(address_a));
    while (hist.size() > RL_A) void'(hist.pop_front());
    data_read_a = (hist.size() == RL_A) ? mem_word(hist[0]) : $urandom();
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [AW_A-1:0] prev_a = '0;
  logic [AW_B-1:0] prev_b = '0;
  bit seq_bad_a = 0, seq_bad_b = 0, wren_ever = 0, done_q_a = 0, done_q_b = 0;

  always @(negedge clk) begin
    exp_t   e;
    probe_t p;
    if (wren_a || wren_b) wren_ever = 1;
    if (!en_a) begin
      prev_a = '0; seq_bad_a = 0;
    end else if (address_a != prev_a) begin
      if (int'(address_a) != int'(prev_a) + 1) seq_bad_a = 1;
      prev_a = address_a;
    end
    if (!en_b) begin
      prev_b = '0; seq_bad_b = 0;
    end else if (address_b != prev_b) begin
      if (int'(address_b) != int'(prev_b) + 1) seq_bad_b = 1;
      prev_b = address_b;
    end

    if (done_a && !done_q_a) begin
      if (exp_a.size() == 0) check("a.unexpected_done", 32'(done_a), 32'd0);
      else begin
        e = exp_a.pop_front();
        check("a.done_cycle", cyc, e.done_cyc);
        check("a.pass", 32'(pass_a), 32'(e.pass));
        check("a.error_count", 32'(errs_a), e.errs);
        check("a.first_error_address", 32'(faddr_a), e.faddr);
        check("a.first_error_data", fdata_a, e.fdata);
        check("a.final_address", 32'(address_a), e.last);
        check("a.address_sequence_ok", 32'(seq_bad_a), 32'd0);
      end
    end
    done_q_a = done_a;

    if (done_b && !done_q_b) begin
      if (exp_b.size() == 0) check("b.unexpected_done", 32'(done_b), 32'd0);
      else begin
        e = exp_b.pop_front();
        check("b.done_cycle", cyc, e.done_cyc);
        check("b.pass", 32'(pass_b), 32'(e.pass));
        check("b.error_count", 32'(errs_b), e.errs);
        check("b.first_error_address", 32'(faddr_b), e.faddr);
        check("b.first_error_data", fdata_b, e.fdata);
        check("b.final_address", 32'(address_b), e.last);
        check("b.address_sequence_ok", 32'(seq_bad_b), 32'd0);
      end
    end
    done_q_b = done_b;

    if (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      if (p.mask[0]) check({p.name, ".address"}, 32'(address_a), p.addr);
      if (p.mask[1]) check({p.name, ".error_count"}, 32'(errs_a), p.errs);
      if (p.mask[2]) check({p.name, ".first_error_address"}, 32'(faddr_a), p.faddr);
      if (p.mask[3]) check({p.name, ".first_error_data"}, fdata_a, p.fdata);
      if (p.mask[4]) check({p.name, ".done"}, 32'(done_a), 32'(p.done));
      if (p.mask[5]) check({p.name, ".pass"}, 32'(pass_a), 32'(p.pass));
    end

    if (finish_req) begin
      check("a.pending_sweeps", exp_a.size(), 32'd0);
      check("b.pending_sweeps", exp_b.size(), 32'd0);
      check("wren_ever_high", 32'(wren_ever), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  function automatic probe_t zero_probe(input string name);
    probe_t p;
    p.name = name; p.mask = 6'b111111;
    p.addr = '0; p.errs = '0; p.faddr = '0; p.fdata = '0; p.done = 0; p.pass = 0;
    return p;
  endfunction

  task automatic run_a(input int pause_pct, input int pause_at, input int pause_len,
                       input int drain_pause);
    bit          plan[$];
    int          issued = 0, held = 0, n = 0, first = -1;
    exp_t        e;
    probe_t      p;
    while (issued < int'(LAST_A) + 1) begin
      bit pz;
      if (issued == pause_at && held < pause_len) begin
        pz = 1; held++;
      end else pz = ($urandom_range(99) < pause_pct);
      plan.push_back(pz);
      if (!pz) issued++;
    end
    foreach (corrupt[k]) begin
      if (k <= int'(LAST_A)) begin
        n++;
        if (first < 0 || k < first) first = k;
      end
    end
    @(posedge clk); #1;
    en_a = 1'b1; pause_a = 1'b0;
    e.done_cyc = cyc + 2 + plan.size() + RL_A;
    e.pass = (n == 0);
    e.errs = n;
    e.faddr = (first < 0) ? 0 : first;
    e.fdata = (first < 0) ? 32'h0 : corrupt[first];
    e.last = LAST_A;
    exp_a.push_back(e);
    foreach (plan[i]) begin
      @(posedge clk); #1;
      pause_a = plan[i];
    end
    for (int k = 0; k < int'(RL_A) + drain_pause + 10 && done_a !== 1'b1; k++) begin
      @(posedge clk); #1;
      pause_a = (k < drain_pause);
    end
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    p = zero_probe("a.done_held"); p.mask = 6'b010000; p.done = 1;
    probe_q.push_back(p);
    en_a = 1'b0; pause_a = 1'b0;
    @(posedge clk); #1;
    probe_q.push_back(zero_probe("a.cleared_after_done"));
  endtask

  task automatic wait_addr_a(input int target);
    probe_t p;
    for (int k = 0; k < 3000 && int'(address_a) != target; k++) begin
      @(posedge clk); #1;
    end
    if (int'(address_a) != target) begin
      p = zero_probe("a.reach_address"); p.mask = 6'b000001; p.addr = target;
      probe_q.push_back(p);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    probe_t p;
    exp_t   e;
    @(posedge clk); #1;
    probe_q.push_back(zero_probe("a.reset_state"));
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    probe_q.push_back(zero_probe("a.idle_after_release"));

    // clean sweep
    corrupt.delete();
    run_a(0, -1, 0, 0);

    // two bad words
    corrupt.delete();
    corrupt[5] = 32'hDEADBEEF;
    corrupt[1000] = $urandom() | 32'h8000_0000;
    run_a(0, -1, 0, 0);

    // 10-cycle pause before address 100 plus pause in drain
    corrupt.delete();
    run_a(0, 100, 10, 3);

    // random corruption and random pause
    for (int s = 0; s < 4; s++) begin
      corrupt.delete();
      repeat ($urandom_range(0, 3)) begin
        int          a = $urandom_range(0, LAST_A + 4);
        logic [31:0] d = $urandom();
        if (d == PAT) d = ~d;
        corrupt[a] = d;
      end
      run_a($urandom_range(0, 30), -1, 0, $urandom_range(0, 4));
    end

    // enable drop mid-sweep with an error logged, then a fresh sweep
    corrupt.delete();
    corrupt[5] = 32'hDEADBEEF;
    @(posedge clk); #1;
    en_a = 1'b1;
    wait_addr_a(500);
    p = zero_probe("a.logged_before_drop"); p.mask = 6'b011110;
    p.errs = 1; p.faddr = 5; p.fdata = 32'hDEADBEEF; p.done = 0;
    probe_q.push_back(p);
    en_a = 1'b0;
    @(posedge clk); #1;
    probe_q.push_back(zero_probe("a.cleared_on_drop"));
    corrupt.delete();
    run_a(0, -1, 0, 0);

    // asynchronous reset between edges mid-sweep
    corrupt[7] = 32'h1234_5678;
    @(posedge clk); #1;
    en_a = 1'b1;
    wait_addr_a(300);
    #2;
    reset_n = 1'b0;
    en_a = 1'b0;
    #1;
    probe_q.push_back(zero_probe("a.async_reset"));
    @(posedge clk); #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
    probe_q.push_back(zero_probe("a.idle_after_async_reset"));
    run_a(10, -1, 0, 1);

    // full 2-bit range, latency 4, every word wrong
    @(posedge clk); #1;
    en_b = 1'b1;
    e.done_cyc = cyc + 2 + (LAST_B + 1) + RL_B;
    e.pass = 0; e.errs = LAST_B + 1; e.faddr = 0; e.fdata = BAD_B; e.last = LAST_B;
    exp_b.push_back(e);
    for (int k = 0; k < 40 && done_b !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    en_b = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    finish_req = 1'b1;
  end

endmodule

// File: doc/memory_verify.md
Name: memory_verify

Overview:
- Read-back checker for the external SRAM. Run it after the blanking pass.
- Sweeps the same address range the blanking writer fills and compares each returned word against the fill pattern.
- Reports pass/fail, the error count, and the first failing address and data.
- Shares the arbitrated memory port with the other sequencers: it obeys pause and uses the same enable/done handshake.

Parameters:
- ADDR_WIDTH, 18, memory address width.
- LAST_ADDRESS, 262141, final address checked (inclusive). Matches the blanking range 0..262141.
- PATTERN, 32'h77553311, expected word at every address.
- READ_LATENCY, 2, cycles from address presentation to valid data_read (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pause  in  1  arbiter hold; no new address is issued while high.
- data_read  in  32  memory read data, valid READ_LATENCY cycles after address.
- wren  out  1  memory write enable; this block never writes, so it is always 0.
- address  out  ADDR_WIDTH  memory read address.
- enable  in  1  start/hold request.
- done  out  1  sweep complete; held high until enable drops.
- pass  out  1  high with done when error_count == 0.
- error_count  out  ADDR_WIDTH+1  mismatching words seen; saturates at all-ones.
- first_error_address  out  ADDR_WIDTH  address of the first mismatch.
- first_error_data  out  32  data_read value at the first mismatch.

Behaviour:
- Reset (async, reset_n low): state=IDLE. All outputs 0 (wren, address, done, pass, error_count, first_error_*). Issue counter 0. Valid pipeline cleared.
- State IDLE: outputs held at 0. enable=1 -> ISSUE, with the issue counter at 0 and error regs cleared.
- State ISSUE, pause=0: drive address=counter, push {valid=1, counter} into a READ_LATENCY-deep tag pipeline, then increment counter. Issuing LAST_ADDRESS moves the FSM to DRAIN.
- State ISSUE, pause=1: address holds its last value and a bubble (valid=0) is pushed.
- Pipeline timing: the tag pipeline advances every cycle regardless of pause. Memory returns data for the earlier address even while paused.
- State DRAIN: push bubbles until the pipeline is empty, then go to DONE.
- State DONE: done=1; pass=(error_count==0). Outputs are frozen.
- Compare stage: when the pipeline output is valid and data_read != PATTERN:
  - error_count increments, saturating.
  - On the first error only (error_count==0 beforehand), capture first_error_address from the tag and first_error_data from data_read.
- Leaving mid-sweep: enable=0 in any state returns to IDLE on the next edge. Counter, pipeline, done, pass and error regs clear. In-flight reads are discarded.
- Holding DONE: enable held high keeps DONE. A new sweep needs enable to go low, then high again.
- Latency: done rises (LAST_ADDRESS+1) + READ_LATENCY + (number of paused cycles during ISSUE) + 1 cycles after enable is sampled high.
- Counter width: ADDR_WIDTH+1 bits, so a LAST_ADDRESS of 2^ADDR_WIDTH-1 does not wrap.
- pause during DRAIN has no effect.
- Simultaneous compare error and enable drop: the drop wins and everything clears.

Decomposition:
- Shared package memory_seq_pkg holds:
  - MEM_ADDR_WIDTH=18, MEM_DATA_WIDTH=32.
  - BLANK_PATTERN=32'h77553311, BLANK_LAST_ADDRESS=262141.
  - State enum {IDLE, ISSUE, DRAIN, DONE}.
  - The blanking writer imports the same constants.
- Sub-module read_tag_pipe: a parameterised depth-N shift register of {valid, address}, reused by future read-side sequencers.

Test Plan:
- Memory model returns 32'h77553311 everywhere, READ_LATENCY=2, enable=1 -> done after 262142+2+1 cycles, pass=1, error_count=0, address sweeps 0..262141, wren stays 0.
- Model corrupts addresses 5 (0xDEADBEEF) and 1000 -> done=1, pass=0, error_count=2, first_error_address=5, first_error_data=32'hDEADBEEF.
- pause high for 10 cycles at address 100 and during DRAIN -> no address skipped or duplicated, done delayed exactly 10 cycles, pass=1.
- enable dropped at address 5000 with an error already logged, then raised again -> outputs clear on the next edge; the fresh sweep starts at address 0 with error_count=0.
- reset_n pulsed low asynchronously mid-sweep (between clock edges) -> all outputs 0 immediately; FSM in IDLE after release.
- LAST_ADDRESS=3, READ_LATENCY=4, every word wrong -> error_count=4, first_error_address=0, done rises 4+4+1 cycles after start.
